// File: rtl/lane_traffic_ctrl.sv
// Lane traffic controller: NUM_CARS cars advanced round-robin, one per clock, once per slow tick.
// Build option CAR_BOUNCE_EN: cars bounce off the lane ends instead of wrapping.
module lane_traffic_ctrl #(
  parameter int NUM_CARS      = 10,
  parameter int X_WIDTH       = 6,
  parameter int Y_WIDTH       = 6,
  parameter int SPEED_WIDTH   = 3,
  parameter int c_MAX_X       = 20,
  parameter int c_SLOW_COUNT  = 2000000,
  parameter int COUNTER_WIDTH = 26
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Enable,
  input  logic                          i_Load,
  input  logic [5:0]                    i_Load_Idx,
  input  logic [X_WIDTH-1:0]            i_Load_X,
  input  logic [Y_WIDTH-1:0]            i_Load_Y,
  input  logic [SPEED_WIDTH-1:0]        i_Load_Speed,
  input  logic                          i_Load_Dir,
  input  logic [X_WIDTH-1:0]            i_Frog_X,
  input  logic [Y_WIDTH-1:0]            i_Frog_Y,
  output logic [NUM_CARS*X_WIDTH-1:0]   o_Car_X,
  output logic [NUM_CARS*Y_WIDTH-1:0]   o_Car_Y,
  output logic                          o_Collision,
  output logic                          o_Sweep_Done
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int XE_W  = X_WIDTH + 1;

  localparam logic [XE_W-1:0]          MAX_X_E    = XE_W'(c_MAX_X);
  localparam logic [X_WIDTH-1:0]       X_LAST     = X_WIDTH'(c_MAX_X - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST   = COUNTER_WIDTH'(c_SLOW_COUNT - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(NUM_CARS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     last_car;
  logic                     sweep_last_q;
  logic [COUNTER_WIDTH-1:0] tick_cnt;
  logic                     tick;

  logic [X_WIDTH-1:0]       car_x     [NUM_CARS];
  logic [Y_WIDTH-1:0]       car_y     [NUM_CARS];
  logic [SPEED_WIDTH-1:0]   car_speed [NUM_CARS];
  logic                     car_dir   [NUM_CARS];

  logic                     load_valid;
  logic [X_WIDTH-1:0]       load_x_clamped;
  logic [XE_W-1:0]          cur_x, step, sum;
  logic [X_WIDTH-1:0]       move_x;
`ifdef CAR_BOUNCE_EN
  logic                     move_dir;
`endif
  logic                     hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tick_cnt <= '0;
    end else if (i_Enable) begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign tick = i_Enable && (tick_cnt == CNT_LAST);

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_car = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d  = IDLE;
          last_car = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Done is delayed one clock past the last car's update.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sweep_last_q <= 1'b0;
      o_Sweep_Done <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sweep_last_q <= last_car;
      o_Sweep_Done <= sweep_last_q;
    end
  end

  // Next position of the car currently addressed by the sweep.
  always_comb begin
    cur_x  = XE_W'(car_x[idx_q]);
    step   = XE_W'(car_speed[idx_q]);
    sum    = cur_x + step;
    move_x = car_x[idx_q];
`ifdef CAR_BOUNCE_EN
    move_dir = car_dir[idx_q];
    if (car_dir[idx_q]) begin
      if (sum >= MAX_X_E) begin
        move_x   = X_LAST;
        move_dir = 1'b0;
      end else begin
        move_x = X_WIDTH'(sum);
      end
    end else begin
      if (cur_x < step) begin
        move_x   = '0;
        move_dir = 1'b1;
      end else begin
        move_x = X_WIDTH'(cur_x - step);
      end
    end
`else
    if (car_dir[idx_q]) begin
      move_x = (sum >= MAX_X_E) ? X_WIDTH'(sum - MAX_X_E) : X_WIDTH'(sum);
    end else begin
      move_x = (cur_x < step) ? X_WIDTH'(cur_x + MAX_X_E - step) : X_WIDTH'(cur_x - step);
    end
`endif
  end

  assign load_valid     = i_Load && ({1'b0, i_Load_Idx} < 7'(NUM_CARS));
  assign load_x_clamped = (XE_W'(i_Load_X) >= MAX_X_E) ? X_LAST : i_Load_X;

  // NOTE: the car table is a register file with defined power-up positions, so it is reset as a whole.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x[i]     <= X_WIDTH'(i % c_MAX_X);
        car_y[i]     <= Y_WIDTH'(i);
        car_speed[i] <= SPEED_WIDTH'(1);
        car_dir[i]   <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_CARS; i++) begin
        if (load_valid && (i_Load_Idx == 6'(i))) begin
          car_x[i]     <= load_x_clamped;
          car_y[i]     <= i_Load_Y;
          car_speed[i] <= i_Load_Speed;
          car_dir[i]   <= i_Load_Dir;
        end else if ((state_q == SWEEP) && (idx_q == IDX_W'(i))) begin
          car_x[i] <= move_x;
`ifdef CAR_BOUNCE_EN
          car_dir[i] <= move_dir;
`endif
        end
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if ((car_x[i] == i_Frog_X) && (car_y[i] == i_Frog_Y)) hit = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) o_Collision <= 1'b0;
    else       o_Collision <= hit;
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
    assign o_Car_X[g*X_WIDTH +: X_WIDTH] = car_x[g];
    assign o_Car_Y[g*Y_WIDTH +: Y_WIDTH] = car_y[g];
  end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Self-checking bench for lane_traffic_ctrl: per-cycle comparison against a time-based
// behavioural model, directed scenarios with literal expectations, then random traffic.
module tb_lane_traffic_ctrl;

  localparam int N    = 4;
  localparam int MAXX = 20;
  localparam int SLOW = 8;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_Enable;
  logic        i_Load;
  logic [5:0]  i_Load_Idx;
  logic [5:0]  i_Load_X;
  logic [5:0]  i_Load_Y;
  logic [2:0]  i_Load_Speed;
  logic        i_Load_Dir;
  logic [5:0]  i_Frog_X;
  logic [5:0]  i_Frog_Y;
  logic [23:0] o_Car_X;
  logic [23:0] o_Car_Y;
  logic        o_Collision;
  logic        o_Sweep_Done;

  lane_traffic_ctrl #(
    .NUM_CARS(N), .X_WIDTH(6), .Y_WIDTH(6), .SPEED_WIDTH(3),
    .c_MAX_X(MAXX), .c_SLOW_COUNT(SLOW), .COUNTER_WIDTH(26)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Load(i_Load),
    .i_Load_Idx(i_Load_Idx), .i_Load_X(i_Load_X), .i_Load_Y(i_Load_Y),
    .i_Load_Speed(i_Load_Speed), .i_Load_Dir(i_Load_Dir),
    .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y),
    .o_Car_X(o_Car_X), .o_Car_Y(o_Car_Y),
    .o_Collision(o_Collision), .o_Sweep_Done(o_Sweep_Done)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks    = 0;
  int n_fail      = 0;
  int done_pulses = 0;

  // Model: car table plus absolute edge numbers; a tick at edge T moves car k at T+1+k.
  int mx [N];
  int my [N];
  int ms [N];
  int md [N];
  int en_cnt    = 0;
  int edge_no   = 0;
  int tick_edge = -100000;
  bit exp_coll  = 1'b0;
  bit exp_done  = 1'b0;
  logic [23:0] ex, ey;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = i % MAXX;
      my[i] = i;
      ms[i] = 1;
      md[i] = 1;
    end
    en_cnt    = 0;
    tick_edge = -100000;
    exp_coll  = 1'b0;
    exp_done  = 1'b0;
  endtask

  task automatic move_car(input int k);
    int s;
    s = ms[k];
`ifdef CAR_BOUNCE_EN
    if (md[k] == 1) begin
      if (mx[k] + s > MAXX - 1) begin mx[k] = MAXX - 1; md[k] = 0; end
      else mx[k] = mx[k] + s;
    end else begin
      if (mx[k] < s) begin mx[k] = 0; md[k] = 1; end
      else mx[k] = mx[k] - s;
    end
`else
    if (md[k] == 1) mx[k] = (mx[k] + s) % MAXX;
    else            mx[k] = (mx[k] - s + MAXX) % MAXX;
`endif
  endtask

  task automatic model_step();
    int k, j;
    bit coll, sweeping, tick;
    edge_no++;
    coll = 1'b0;
    for (int i = 0; i < N; i++)
      if (mx[i] == int'(i_Frog_X) && my[i] == int'(i_Frog_Y)) coll = 1'b1;
    k        = edge_no - tick_edge - 1;
    sweeping = (k >= 0) && (k < N);
    exp_done = (edge_no - tick_edge == N + 1);
    tick     = i_Enable && (en_cnt % SLOW == SLOW - 1) && !sweeping;
    if (i_Enable) en_cnt++;
    if (sweeping) move_car(k);
    if (tick) tick_edge = edge_no;
    if (i_Load && int'(i_Load_Idx) < N) begin
      j     = int'(i_Load_Idx);
      mx[j] = (int'(i_Load_X) >= MAXX) ? MAXX - 1 : int'(i_Load_X);
      my[j] = int'(i_Load_Y);
      ms[j] = int'(i_Load_Speed);
      md[j] = int'(i_Load_Dir);
    end
    exp_coll = coll;
  endtask

  // Compare process: advance the model at each edge, check the DUT 1 ns later.
  always @(posedge i_Clk) begin
    if (i_Rst) model_reset();
    else       model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      ex[i*6 +: 6] = 6'(mx[i]);
      ey[i*6 +: 6] = 6'(my[i]);
    end
    check("car_x", 64'(o_Car_X), 64'(ex));
    check("car_y", 64'(o_Car_Y), 64'(ey));
    check("collision", 64'(o_Collision), 64'(exp_coll));
    check("sweep_done", 64'(o_Sweep_Done), 64'(exp_done));
    if (o_Sweep_Done) done_pulses++;
  end

  task automatic step();
    @(posedge i_Clk);
    #3;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_Sweep_Done && n < 40);
    if (!o_Sweep_Done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout no sweep_done within %0d cycles", n);
    end
  endtask

  task automatic do_load(input int idx, input int x, input int y, input int s, input int d);
    i_Load       = 1'b1;
    i_Load_Idx   = 6'(idx);
    i_Load_X     = 6'(x);
    i_Load_Y     = 6'(y);
    i_Load_Speed = 3'(s);
    i_Load_Dir   = 1'(d);
    step();
    i_Load = 1'b0;
  endtask

  function automatic int cx(input int i);
    return int'(o_Car_X[i*6 +: 6]);
  endfunction

  initial begin
    int n;
    i_Rst = 1'b1; i_Enable = 1'b0; i_Load = 1'b0;
    i_Load_Idx = '0; i_Load_X = '0; i_Load_Y = '0; i_Load_Speed = '0; i_Load_Dir = 1'b0;
    i_Frog_X = 6'd0; i_Frog_Y = 6'd63;
    repeat (3) step();
    i_Rst = 1'b0;

    // Idle with the counter disabled: reset positions hold, no sweep.
    repeat (50) step();
    check("idle_x", 64'(o_Car_X), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
    check("idle_y", 64'(o_Car_Y), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
    check("idle_no_done", 64'(done_pulses), 64'(0));
    check("idle_coll", 64'(o_Collision), 64'(0));

    // First tick after 8 enabled clocks, done 5 clocks later.
    i_Enable = 1'b1;
    wait_done(n);
    check("enable_to_done", 64'(n), 64'(13));
    check("sweep1_x", 64'(o_Car_X), 64'({6'd4, 6'd3, 6'd2, 6'd1}));

    // Lane-end behaviour.
    do_load(1, 19, 1, 3, 1);
    do_load(2, 1, 2, 3, 0);
    wait_done(n);
`ifdef CAR_BOUNCE_EN
    check("edge_right", 64'(cx(1)), 64'(19));
    check("edge_left", 64'(cx(2)), 64'(0));
`else
    check("edge_right", 64'(cx(1)), 64'(2));
    check("edge_left", 64'(cx(2)), 64'(18));
`endif

    // Clamp, then a load colliding with car0's own sweep update.
    do_load(2, 25, 2, 3, 0);
    check("load_clamp", 64'(cx(2)), 64'(19));
    step();
    step();
    do_load(0, 7, 0, 1, 1);
    check("load_beats_sweep", 64'(cx(0)), 64'(7));

    // Collision set and clear.
    i_Frog_X = 6'd5; i_Frog_Y = 6'd2;
    do_load(2, 5, 2, 0, 1);
    step();
    check("coll_set", 64'(o_Collision), 64'(1));
    i_Frog_X = 6'd6;
    step();
    check("coll_clear", 64'(o_Collision), 64'(0));

    // Reset while car1 is being updated.
    wait_done(n);
    repeat (4) step();
    i_Rst = 1'b1;
    #1;
    check("rst_x", 64'(o_Car_X), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
    check("rst_y", 64'(o_Car_Y), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
    check("rst_done", 64'(o_Sweep_Done), 64'(0));
    step();
    i_Rst = 1'b0;
    done_pulses = 0;
    repeat (12) step();
    check("post_rst_no_early_done", 64'(done_pulses), 64'(0));
    step();
    check("post_rst_done", 64'(o_Sweep_Done), 64'(1));
    check("post_rst_x", 64'(o_Car_X), 64'({6'd4, 6'd3, 6'd2, 6'd1}));
    check("post_rst_one_done", 64'(done_pulses), 64'(1));

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      i_Enable     = ($urandom_range(7) != 0);
      i_Load       = ($urandom_range(2) == 0);
      i_Load_Idx   = 6'($urandom_range(5));
      i_Load_X     = 6'($urandom_range(31));
      i_Load_Y     = 6'($urandom_range(4));
      i_Load_Speed = 3'($urandom);
      i_Load_Dir   = 1'($urandom);
      if ($urandom_range(3) == 0) begin
        i_Frog_X = 6'($urandom_range(MAXX - 1));
        i_Frog_Y = 6'($urandom_range(4));
      end
      i_Rst = ($urandom_range(199) == 0);
      step();
    end
    i_Rst  = 1'b0;
    i_Load = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
